// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the two requester ports (instruction fetch I, data D)
// and the single-port RAM macro port of ram_arbiter.
//   I port : i_req/i_addr in, i_gnt/i_rvalid/i_rdata out
//   D port : d_req/d_we/d_addr/d_wdata in, d_gnt/d_rvalid/d_rdata out
//   status : err out (pulses with the rvalid of an out-of-range access)
//   RAM    : ram_en/ram_rw/ram_addr/ram_wdata out, ram_rdata in
// Modports: master = requesters + RAM model side, slave = arbiter side.
interface ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              err;

    logic              ram_en;
    logic              ram_rw;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, err,
               ram_en, ram_rw, ram_addr, ram_wdata
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, err,
               ram_en, ram_rw, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between the instruction-fetch (I)
// and data (D) ports. One request is accepted per IDLE cycle, the RAM is
// driven for exactly one ACCESS cycle, and the result comes back registered
// with a one-cycle rvalid pulse on the owning port.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : ram_arbiter_if.slave (requester ports, err, RAM port)
// Build option:
//   ARB_RR_EN defined   -> round-robin on simultaneous requests (1-bit
//                          last-owner register, reset value = I)
//   ARB_RR_EN undefined -> fixed priority, D wins every tie
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            r_state;
    logic              r_owner_d;    // 1 = D owns the current access
    logic              r_oor;        // latched address is outside the RAM
    logic              r_ram_en;
    logic              r_ram_rw;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_i_rvalid;
    logic              r_d_rvalid;
    logic              r_err;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_idle;
    logic              w_d_wins;
    logic              w_i_gnt;
    logic              w_d_gnt;
    logic [31:0]       w_sel_addr;
    logic              w_sel_oor;
    logic [DATA_W-1:0] w_rd_data;

    // Grants are combinational and forced low while reset is asserted.
    assign w_idle = (r_state == IDLE) && !reset;

`ifdef ARB_RR_EN
    logic r_last_d;  // owner of the most recent grant, 0 = I
    // On a tie the requester not served last wins.
    assign w_d_wins = !bus.i_req || !r_last_d;
`else
    assign w_d_wins = 1'b1;
`endif

    assign w_d_gnt = w_idle && bus.d_req && w_d_wins;
    assign w_i_gnt = w_idle && bus.i_req && !w_d_gnt;

    assign w_sel_addr = w_d_gnt ? bus.d_addr : bus.i_addr;
    assign w_sel_oor  = |w_sel_addr[31:ADDR_W];

    // Writes and out-of-range accesses return zero instead of RAM data.
    assign w_rd_data = (r_oor || r_ram_rw) ? '0 : bus.ram_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner_d   <= 1'b0;
            r_oor       <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_rw    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_i_rvalid  <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_err       <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
`ifdef ARB_RR_EN
            r_last_d    <= 1'b0;
`endif
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_d_gnt || w_i_gnt) begin
                        r_owner_d   <= w_d_gnt;
                        r_oor       <= w_sel_oor;
                        r_ram_en    <= !w_sel_oor;
                        r_ram_rw    <= w_d_gnt && bus.d_we;
                        r_ram_addr  <= w_sel_addr[ADDR_W-1:0];
                        r_ram_wdata <= w_d_gnt ? bus.d_wdata : '0;
`ifdef ARB_RR_EN
                        r_last_d    <= w_d_gnt;
`endif
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_owner_d) begin
                        r_d_rvalid <= 1'b1;
                        r_d_rdata  <= w_rd_data;
                    end else begin
                        r_i_rvalid <= 1'b1;
                        r_i_rdata  <= w_rd_data;
                    end
                    r_err       <= r_oor;
                    r_ram_en    <= 1'b0;
                    r_ram_rw    <= 1'b0;
                    r_ram_addr  <= '0;
                    r_ram_wdata <= '0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.i_gnt     = w_i_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.i_rvalid  = r_i_rvalid;
    assign bus.d_rvalid  = r_d_rvalid;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.err       = r_err;
    assign bus.ram_en    = r_ram_en;
    assign bus.ram_rw    = r_ram_rw;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter. A behavioural 256x32
// RAM sits on the RAM port; expected results are queued at grant time and
// popped when an rvalid pulse appears.
module tb_ram_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM model: combinational read, synchronous write.
    logic [31:0] mem     [256];
    logic [31:0] exp_mem [256];
    always @(posedge clk) if (bus.ram_en && bus.ram_rw) mem[bus.ram_addr] <= bus.ram_wdata;
    assign bus.ram_rdata = bus.ram_en ? mem[bus.ram_addr] : 32'hBAD0_BAD0;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Raise a request, wait for its grant, queue the expected result and
    // release the request right after the accepting edge.
    task automatic req_access(input logic is_d, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, output int gcyc);
        bit   got = 0;
        exp_t e;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        gcyc = -1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (is_d ? bus.d_gnt : bus.i_gnt) got = 1;
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL grant_timeout %s addr=%0d: no grant seen, required within 20 cycles",
                     is_d ? "D" : "I", addr);
        end else begin
            gcyc   = cyc;
            e.is_d = is_d;
            e.err  = (addr >= 256);
            e.data = (e.err || (is_d && we)) ? 32'h0 : exp_mem[addr[7:0]];
            sb.push_back(e);
            if (is_d && we && !e.err) exp_mem[addr[7:0]] = wdata;
        end
        @(posedge clk); #1;
        if (is_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.i_gnt, bus.d_gnt} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_gnt: got %b, required 00", {bus.i_gnt, bus.d_gnt});
        end
        vectors++;
        if ({bus.i_rvalid, bus.d_rvalid, bus.err, bus.ram_en, bus.ram_rw} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b, required 00000",
                     {bus.i_rvalid, bus.d_rvalid, bus.err, bus.ram_en, bus.ram_rw});
        end
        vectors++;
        if ({bus.i_rdata, bus.d_rdata, bus.ram_wdata, bus.ram_addr} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got i=%h d=%h wd=%h a=%h, required all 0",
                     bus.i_rdata, bus.d_rdata, bus.ram_wdata, bus.ram_addr);
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_i_read();
        int c0, g;
        c0 = cyc;
        req_access(1'b0, 1'b0, 32'd5, 32'h0, g);
        vectors++;
        if (g !== c0) begin
            miscompares++;
            $display("FAIL i_gnt_latency: granted in cycle %0d, required %0d", g, c0);
        end
        @(negedge clk);
        vectors++;
        if ({bus.ram_en, bus.ram_rw, bus.ram_addr, bus.i_gnt} !== {1'b1, 1'b0, 8'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL i_access_cycle: en=%b rw=%b addr=%0d gnt=%b, required en=1 rw=0 addr=5 gnt=0",
                     bus.ram_en, bus.ram_rw, bus.ram_addr, bus.i_gnt);
        end
        @(negedge clk);
        vectors++;
        if ({bus.i_rvalid, bus.err, bus.ram_en} !== 3'b100) begin
            miscompares++;
            $display("FAIL i_result_cycle: rvalid=%b err=%b en=%b, required 1 0 0",
                     bus.i_rvalid, bus.err, bus.ram_en);
        end
        drain();
    endtask

    task automatic test_d_write_read();
        int g;
        req_access(1'b1, 1'b1, 32'd10, 32'hDEADBEEF, g);
        @(negedge clk);
        vectors++;
        if ({bus.ram_en, bus.ram_rw, bus.ram_addr, bus.ram_wdata} !== {1'b1, 1'b1, 8'd10, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL d_write_cycle: en=%b rw=%b addr=%0d wdata=%h, required 1 1 10 deadbeef",
                     bus.ram_en, bus.ram_rw, bus.ram_addr, bus.ram_wdata);
        end
        drain();
        vectors++;
        if (bus.i_rdata !== 32'hE3A00001) begin
            miscompares++;
            $display("FAIL i_rdata_hold: got %h, required e3a00001", bus.i_rdata);
        end
        req_access(1'b1, 1'b0, 32'd10, 32'h0, g);
        drain();
    endtask

    task automatic test_arbitration();
        logic [7:0] seq = '0;
        logic [7:0] exp_seq;
        int n = 0;
        bit both = 0;
        exp_t e;
`ifdef ARB_RR_EN
        exp_seq = 8'b0101_0101;
`else
        exp_seq = 8'b1111_1111;
`endif
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'd1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd2;
        for (int k = 0; k < 40 && n < 8; k++) begin
            @(negedge clk);
            if (bus.i_gnt && bus.d_gnt) both = 1;
            if (bus.d_gnt || bus.i_gnt) begin
                e.is_d = bus.d_gnt;
                e.err  = 1'b0;
                e.data = exp_mem[bus.d_gnt ? 2 : 1];
                sb.push_back(e);
                seq[n] = bus.d_gnt;
                n++;
            end
        end
        @(posedge clk); #1;
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        vectors++;
        if (both !== 1'b0) begin
            miscompares++;
            $display("FAIL arb_dual_grant: both grants seen high, required never");
        end
        vectors++;
        if (n != 8 || seq !== exp_seq) begin
            miscompares++;
            $display("FAIL arb_order: %0d grants, D-bits %b, required 8 grants, %b", n, seq, exp_seq);
        end
        drain();
    endtask

    task automatic test_out_of_range();
        int g;
        req_access(1'b1, 1'b0, 32'd300, 32'h0, g);
        @(negedge clk);
        vectors++;
        if (bus.ram_en !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_ram_en: got %b, required 0", bus.ram_en);
        end
        @(negedge clk);
        vectors++;
        if ({bus.d_rvalid, bus.err} !== 2'b11) begin
            miscompares++;
            $display("FAIL oor_result: rvalid=%b err=%b, required 1 1", bus.d_rvalid, bus.err);
        end
        drain();
    endtask

    task automatic test_reset_mid_access();
        int g;
        bit seen = 0;
        req_access(1'b0, 1'b0, 32'd3, 32'h0, g);
        vectors++;
        if (bus.ram_en !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_access_en: got %b, required 1 before reset", bus.ram_en);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus.ram_en, bus.ram_rw, bus.i_rvalid, bus.d_rvalid, bus.err} !== 5'b0 || bus.ram_addr !== '0) begin
            miscompares++;
            $display("FAIL async_reset: en=%b rw=%b iv=%b dv=%b err=%b addr=%0d, required all 0",
                     bus.ram_en, bus.ram_rw, bus.i_rvalid, bus.d_rvalid, bus.err, bus.ram_addr);
        end
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.i_rvalid || bus.d_rvalid) seen = 1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL abandoned_rvalid: rvalid seen after reset, required none");
        end
        @(posedge clk); #1;
        req_access(1'b0, 1'b0, 32'd0, 32'h0, g);
        drain();
    endtask

    task automatic test_back_to_back();
        int g, prev;
        prev = -1;
        for (int a = 0; a < 18; a++) begin
            req_access(1'b0, 1'b0, a, 32'h0, g);
            if (a > 0) begin
                vectors++;
                if (g - prev != 2) begin
                    miscompares++;
                    $display("FAIL b2b_spacing addr=%0d: %0d cycles between grants, required 2", a, g - prev);
                end
            end
            prev = g;
        end
        drain();
    endtask

    initial begin
        exp_t e;
        logic act_d;
        logic [31:0] act_data;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            exp_mem[i] = mem[i];
        end
        mem[5] = 32'hE3A00001; exp_mem[5] = 32'hE3A00001;
        bus.i_req = 0; bus.i_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        reset = 1'b1;

        // Scoreboard monitor: every rvalid pulse pops one expected result.
        fork
            forever begin
                @(negedge clk);
                if (bus.i_rvalid || bus.d_rvalid) begin
                    vectors++;
                    act_d    = bus.d_rvalid;
                    act_data = act_d ? bus.d_rdata : bus.i_rdata;
                    if (bus.i_rvalid && bus.d_rvalid) begin
                        miscompares++;
                        $display("FAIL result_dual_valid: both rvalids high, required one");
                    end else if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL result_unexpected: %s rvalid data=%h, required no result",
                                 act_d ? "D" : "I", act_data);
                    end else begin
                        e = sb.pop_front();
                        if (act_d !== e.is_d || act_data !== e.data || bus.err !== e.err) begin
                            miscompares++;
                            $display("FAIL result: got %s data=%h err=%b, required %s data=%h err=%b",
                                     act_d ? "D" : "I", act_data, bus.err,
                                     e.is_d ? "D" : "I", e.data, e.err);
                        end
                    end
                end else if (bus.err) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL err_alone: err=1 without rvalid, required 0");
                end
            end
        join_none

        test_reset();
        test_i_read();
        test_d_write_read();
        test_arbitration();
        test_out_of_range();
        test_reset_mid_access();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
